// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Parametrised UART transmitter with a small transmit FIFO in front of it.
// The bus side pushes words into the FIFO at up to one per clock. The frame
// engine pops one word at a time and serialises it as:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1).
//
// Ports:
//   i_Clock       system clock, all logic on the rising edge
//   i_Rst_n       asynchronous active-low reset; aborts any frame and
//                 discards queued data
//   i_Tx_DV       write strobe; one push per cycle while high and ready
//   i_Tx_Byte     word to queue, sampled together with i_Tx_DV
//   o_Tx_Ready    FIFO not full
//   o_Fifo_Count  queued entries, not counting the frame on the line
//   o_Tx_Active   high from the start bit through the last stop bit
//   o_Tx_Serial   serial line, idle high, registered
//   o_Tx_Done     one-cycle pulse after each frame's last stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Sized for twice a bit period so a two-stop-bit period fits in one count.
    localparam int CLK_W = $clog2(CLKS_PER_BIT * 2);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CLK_W-1:0] BIT_LAST   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] STOP_LAST  = CLK_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Transmit FIFO
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [DATA_BITS-1:0] head_data;
    logic                 push;
    logic                 pop;

    state_t               state_reg;

    assign o_Tx_Ready   = (count_reg != FULL_COUNT);
    assign o_Fifo_Count = count_reg;
    assign push         = i_Tx_DV && o_Tx_Ready;
    // The frame engine takes the head only while idle, so an IDLE visit with
    // data waiting lasts exactly one clock.
    assign pop          = (state_reg == S_IDLE) && (count_reg != '0);
    assign head_data    = fifo_mem[rd_ptr_reg];

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= i_Tx_Byte;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame engine
    // -----------------------------------------------------------------------
    logic [CLK_W-1:0]     clk_cnt_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 parity_reg;
    logic                 serial_reg;
    logic                 active_reg;
    logic                 done_reg;
    logic                 line_next;

    // Level the current state wants on the line. It is registered into
    // serial_reg, so the pin lags the state by one clock; that lag is what
    // puts the start bit two edges after a push into an idle block.
    always_comb begin
        line_next = 1'b1;
        case (state_reg)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = data_reg[bit_idx_reg];
            S_PARITY: line_next = parity_reg;
            default:  line_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg   <= S_IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            serial_reg  <= 1'b1;
            active_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            serial_reg <= line_next;
            done_reg   <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    clk_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    if (pop) begin
                        // Latch the word so later writes cannot disturb it.
                        data_reg    <= head_data;
                        // Even parity is the XOR of the data; odd inverts it.
                        parity_reg  <= (PARITY_MODE == 1) ? ~^head_data : ^head_data;
                        active_reg  <= 1'b1;
                        state_reg   <= S_START;
                    end
                end

                S_START: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        state_reg   <= S_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CLK_W'(1);
                    end
                end

                S_DATA: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        if (bit_idx_reg == IDX_LAST) begin
                            bit_idx_reg <= '0;
                            state_reg   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CLK_W'(1);
                    end
                end

                S_PARITY: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        state_reg   <= S_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CLK_W'(1);
                    end
                end

                S_STOP: begin
                    // All stop bits are timed as one continuous period.
                    if (clk_cnt_reg == STOP_LAST) begin
                        clk_cnt_reg <= '0;
                        active_reg  <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= S_IDLE;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CLK_W'(1);
                    end
                end

                default: begin
                    // Unreachable encodings recover to idle; line_next is
                    // already high for them.
                    clk_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    active_reg  <= 1'b0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Serial = serial_reg;
    assign o_Tx_Active = active_reg;
    assign o_Tx_Done   = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Four transmitter instances share clock and reset:
//   lane 0: 8N1, lane 1: 8 data even parity, lane 2: 8 data odd parity,
//   lane 3: 7 data no parity 2 stop. All at 4 clocks per bit, FIFO depth 4.
// Stimulus pushes expected frames into a scoreboard queue; a per-lane
// receiver process decodes the line and pops/compares each frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       par;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] dv;
    logic [8:0] tx_byte;
    logic [3:0] ready;
    logic [3:0] active;
    logic [3:0] ser;
    logic [3:0] done;
    logic [2:0] cnt [4];

    int   tests;
    int   fails;
    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int DB = (gi == 3) ? 7 : 8;
        localparam int PM = (gi == 1) ? 2 : ((gi == 2) ? 1 : 0);
        localparam int SB = (gi == 3) ? 2 : 1;
        localparam int NB = 1 + DB + ((PM != 0) ? 1 : 0) + SB;

        uart_tx_fifo #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_MODE  (PM),
            .STOP_BITS    (SB),
            .FIFO_DEPTH   (4)
        ) dut (
            .i_Clock      (clk),
            .i_Rst_n      (rst_n),
            .i_Tx_DV      (dv[gi]),
            .i_Tx_Byte    (tx_byte[DB-1:0]),
            .o_Tx_Ready   (ready[gi]),
            .o_Fifo_Count (cnt[gi]),
            .o_Tx_Active  (active[gi]),
            .o_Tx_Serial  (ser[gi]),
            .o_Tx_Done    (done[gi])
        );

        // Receiver: every sample of every bit must agree, which also checks
        // that each bit lasts exactly CPB clocks.
        bit          ok;
        bit          aborted;
        logic [8:0]  d;
        logic        p;
        logic        first_s;
        exp_t        e;
        logic [14:0] got_v;
        logic [14:0] exp_v;

        always begin : mon
            @(negedge clk);
            if (rst_n && ser[gi] == 1'b0) begin
                ok = 1'b1;
                aborted = 1'b0;
                d = '0;
                p = 1'b0;
                first_s = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                        if (c == 0) begin
                            first_s = ser[gi];
                            if (b == 0) begin
                                if (first_s !== 1'b0) ok = 1'b0;
                            end else if (b <= DB) begin
                                d[b-1] = first_s;
                            end else if (PM != 0 && b == DB + 1) begin
                                p = first_s;
                            end else if (first_s !== 1'b1) begin
                                ok = 1'b0;
                            end
                        end else if (ser[gi] !== first_s) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (!aborted) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL frame lane%0d: got data 0x%0h, expected no frame", gi, d);
                    end else begin
                        e = sb_q.pop_front();
                        got_v = {ok, 4'(gi), (PM != 0) ? p : 1'b0, d};
                        exp_v = {1'b1, 4'(e.id), (PM != 0) ? e.par : 1'b0, e.data};
                        chk($sformatf("frame lane%0d", gi), 32'(got_v), 32'(exp_v));
                        $display("[TB] lane%0d frame data=0x%0h par=%0b well_formed=%0b",
                                 gi, d, p, ok);
                    end
                end
            end
        end
    end

    task automatic expect_frame(int k, logic [8:0] b, logic par);
        exp_t e;
        e.id = k;
        e.data = b;
        e.par = par;
        sb_q.push_back(e);
    endtask

    // Caller is just after a rising edge; the push happens on the next edge
    // and the task returns just after it. The data bus is then scrambled.
    task automatic push(int k, logic [8:0] b);
        dv[k] = 1'b1;
        tx_byte = b;
        @(posedge clk);
        #1;
        dv[k] = 1'b0;
        tx_byte = ~b;
    endtask

    task automatic wait_idle(int k);
        int n;
        n = 0;
        while ((active[k] || cnt[k] != 3'd0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("idle_wait lane%0d", k), 32'(n < 2000), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk($sformatf("scoreboard_empty lane%0d", k), 32'(sb_q.size()), 32'd0);
    endtask

    // Push into an idle lane and time the frame from the push edge T.
    task automatic send_and_time(int k, logic [8:0] b, logic par, int exp_len);
        int act_n;
        int done_n;
        expect_frame(k, b, par);
        push(k, b);
        @(posedge clk); #1;                       // T+1
        chk($sformatf("serial_T+1 lane%0d", k), 32'(ser[k]), 32'd1);
        chk($sformatf("active_T+1 lane%0d", k), 32'(active[k]), 32'd1);
        act_n = 1;
        done_n = 0;
        @(posedge clk); #1;                       // T+2
        chk($sformatf("serial_T+2 lane%0d", k), 32'(ser[k]), 32'd0);
        for (int i = 0; i < 200; i++) begin
            if (done[k]) done_n++;
            if (!active[k]) break;
            act_n++;
            @(posedge clk); #1;
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (done[k]) done_n++;
        end
        chk($sformatf("active_len lane%0d", k), 32'(act_n), 32'(exp_len));
        chk($sformatf("done_pulses lane%0d", k), 32'(done_n), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        dv = '0;
        tx_byte = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state on every lane.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst serial lane%0d", k), 32'(ser[k]), 32'd1);
            chk($sformatf("rst active lane%0d", k), 32'(active[k]), 32'd0);
            chk($sformatf("rst done lane%0d", k), 32'(done[k]), 32'd0);
            chk($sformatf("rst ready lane%0d", k), 32'(ready[k]), 32'd1);
            chk($sformatf("rst count lane%0d", k), 32'(cnt[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8N1 0xA5: 10 bits x 4 clocks.
        send_and_time(0, 9'h0A5, 1'b0, 40);
        wait_idle(0);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0; 11 bits.
        send_and_time(1, 9'h007, 1'b1, 44);
        wait_idle(1);
        send_and_time(2, 9'h007, 1'b0, 44);
        wait_idle(2);

        // 7 data, 2 stop: 0x7F then 0x2A back to back (push edges T, T+1).
        expect_frame(3, 9'h07F, 1'b0);
        expect_frame(3, 9'h02A, 1'b0);
        push(3, 9'h07F);
        push(3, 9'h02A);
        repeat (40) @(posedge clk);
        #1;                                       // T+41: last stop edge
        chk("2stop done_T+41", 32'(done[3]), 32'd1);
        chk("2stop active_T+41", 32'(active[3]), 32'd0);
        chk("2stop serial_T+41", 32'(ser[3]), 32'd1);
        @(posedge clk); #1;                       // T+42: one clock of IDLE
        chk("2stop serial_T+42", 32'(ser[3]), 32'd1);
        chk("2stop active_T+42", 32'(active[3]), 32'd1);
        @(posedge clk); #1;                       // T+43: next start bit
        chk("2stop serial_T+43", 32'(ser[3]), 32'd0);
        wait_idle(3);

        // Five back-to-back pushes all fit (first is popped at once);
        // a sixth while full is dropped.
        expect_frame(0, 9'h011, 1'b0);
        expect_frame(0, 9'h022, 1'b0);
        expect_frame(0, 9'h033, 1'b0);
        expect_frame(0, 9'h044, 1'b0);
        expect_frame(0, 9'h055, 1'b0);
        push(0, 9'h011);
        push(0, 9'h022);
        push(0, 9'h033);
        push(0, 9'h044);
        push(0, 9'h055);
        chk("full count", 32'(cnt[0]), 32'd4);
        chk("full ready", 32'(ready[0]), 32'd0);
        push(0, 9'h066);
        chk("full count after drop", 32'(cnt[0]), 32'd4);
        wait_idle(0);

        // Push on the final stop clock with an empty FIFO.
        expect_frame(0, 9'h03C, 1'b0);
        push(0, 9'h03C);                          // edge T
        repeat (40) @(posedge clk);
        #1;                                       // T+40
        chk("laststop active_T+40", 32'(active[0]), 32'd1);
        expect_frame(0, 9'h0C3, 1'b0);
        push(0, 9'h0C3);                          // edge T+41
        chk("laststop done_T+41", 32'(done[0]), 32'd1);
        chk("laststop count_T+41", 32'(cnt[0]), 32'd1);
        @(posedge clk); #1;                       // T+42
        chk("laststop serial_T+42", 32'(ser[0]), 32'd1);
        chk("laststop done_T+42", 32'(done[0]), 32'd0);
        @(posedge clk); #1;                       // T+43
        chk("laststop serial_T+43", 32'(ser[0]), 32'd0);
        chk("laststop done_T+43", 32'(done[0]), 32'd0);
        wait_idle(0);

        // Reset during data bit 3 of 0x00 with two words still queued.
        expect_frame(0, 9'h000, 1'b0);
        expect_frame(0, 9'h081, 1'b0);
        expect_frame(0, 9'h042, 1'b0);
        push(0, 9'h000);                          // edge T
        push(0, 9'h081);
        push(0, 9'h042);
        repeat (17) @(posedge clk);
        #1;                                       // T+19: bit 3 on the line
        chk("midrst serial_before", 32'(ser[0]), 32'd0);
        chk("midrst count_before", 32'(cnt[0]), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;                                       // no clock edge since reset
        chk("midrst serial", 32'(ser[0]), 32'd1);
        chk("midrst active", 32'(active[0]), 32'd0);
        chk("midrst count", 32'(cnt[0]), 32'd0);
        chk("midrst ready", 32'(ready[0]), 32'd1);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (active[0] || !ser[0] || cnt[0] != 3'd0) seen++;
        end
        chk("midrst no residual frame", 32'(seen), 32'd0);
        chk("midrst scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the bus UART protocol folder.
- Configurable data width, parity mode and stop-bit count.
- Includes a small transmit FIFO so the bus side can queue bytes back-to-back without waiting for each frame.
- Sits between the UART register interface (write side) and the serial pin.

Parameters:
- CLKS_PER_BIT, 87, clocks per serial bit; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, parity select: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Tx_DV  in  1  write strobe; one entry pushed per cycle while high and o_Tx_Ready is high.
- i_Tx_Byte  in  DATA_BITS  data to queue, sampled with i_Tx_DV.
- o_Tx_Ready  out  1  FIFO not full.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  number of queued entries, excluding the frame currently on the line.
- o_Tx_Active  out  1  high from the start bit through the last stop bit.
- o_Tx_Serial  out  1  serial line, idle high; registered output.
- o_Tx_Done  out  1  one-cycle pulse after each frame's last stop bit.

Behaviour:
- Reset (asynchronous, i_Rst_n=0):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Fifo_Count=0.
  - FIFO pointers cleared; state IDLE; bit and clock counters 0.
  - Reset mid-frame aborts the frame: line goes high immediately and queued data is discarded.
- FIFO:
  - Push when i_Tx_DV & o_Tx_Ready.
  - i_Tx_DV while full is ignored; no overwrite, no error flag.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - o_Tx_Ready = (count != FIFO_DEPTH), combinational from the registered count.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: drive 1. If count>0, pop the head into the shift register, set o_Tx_Active, go to START.
  - START: drive 0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: drive data LSB first, each bit for CLKS_PER_BIT clocks. After bit DATA_BITS-1, go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: drive the parity bit for CLKS_PER_BIT clocks, then go to STOP.
    - Even: XOR of the data bits.
    - Odd: inverse of that XOR.
  - STOP: drive 1 for STOP_BITS*CLKS_PER_BIT clocks. At the final clock, clear o_Tx_Active, pulse o_Tx_Done for exactly 1 cycle, go to IDLE.
- Timing:
  - A push at edge T into an empty, idle block makes o_Tx_Serial go low at edge T+2.
  - Each bit occupies exactly CLKS_PER_BIT clocks on o_Tx_Serial.
  - Frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
  - Back-to-back frames: IDLE lasts exactly 1 cycle when the FIFO is non-empty, so the next start bit follows the last stop bit with exactly one extra clock of mark.
- Widths and encodings:
  - Clock counter width = $clog2(CLKS_PER_BIT*2); it must not overflow during a 2-stop-bit period.
  - Bit index width = $clog2(DATA_BITS).
  - Unused state encodings return to IDLE with the line high.
- Input stability: i_Tx_Byte changes after acceptance do not affect queued or in-flight data.

Test Plan:
- CLKS_PER_BIT=4, 8N1, push 0xA5 at edge T -> line low at T+2. Bits 1,0,1,0,0,1,0,1 each 4 clocks, then 4 clocks high. o_Tx_Done pulses once at frame end; o_Tx_Active high for exactly 40 clocks.
- PARITY_MODE=2, push 0x07 -> parity bit 1. Repeat with PARITY_MODE=1 -> parity bit 0. Frame is 11 bits.
- STOP_BITS=2, DATA_BITS=7, push 0x7F -> stop level held 8 clocks; next queued frame's start bit begins 1 clock later.
- FIFO_DEPTH=4, idle line, five consecutive i_Tx_DV pulses (0x11..0x55) -> after the first pop, 0x22..0x55 are queued. Count reaches 4 and o_Tx_Ready goes low. Later pushes are dropped while full. Transmitted order is 0x11, 0x22, 0x33, 0x44, 0x55 only if each push is accepted; bench checks that a push attempted while full is lost.
- Push during the last STOP clock with count=0 -> next start bit follows with the 1-cycle IDLE gap; no spurious o_Tx_Done.
- Assert i_Rst_n=0 mid-DATA bit 3 -> o_Tx_Serial=1 and o_Tx_Active=0 without a clock edge, count=0. After release, no residual frame is sent.
